// File: rtl/aes_key_round_ctrl_if.sv
// Handshake bundle between the AES round controller and its key/data producer and consumer.
// The master side offers keys and blocks and takes results; the controller is the slave.
interface aes_key_round_ctrl_if;

   logic         key_valid;
   logic [127:0] key_in;
   logic         key_ready;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output key_valid,
      output key_in,
      output in_valid,
      output out_ready,
      input  key_ready,
      input  in_ready,
      input  out_valid
   );

   modport slave (
      input  key_valid,
      input  key_in,
      input  in_valid,
      input  out_ready,
      output key_ready,
      output in_ready,
      output out_valid
   );

endinterface

// File: rtl/aes_key_round_ctrl.sv
// Sequencer for an iterative AES-128 core: streams the cipher key serially into the key
// generator, waits for the round keys, then steps the datapath through ten rounds per block.
module aes_key_round_ctrl #(
   parameter int unsigned KG_LAT = 176
) (
   input  logic                 clk,
   input  logic                 reset,
   aes_key_round_ctrl_if.slave  bus,
   output logic                 kg_reset_n,
   output logic                 kg_k_in,
   output logic [3:0]           round_idx,
   output logic                 dp_ld,
   output logic                 dp_rnd_en,
   output logic                 dp_final,
   output logic                 key_loaded,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE_NOKEY,
      KRST,
      KLOAD,
      KWAIT,
      READY,
      ROUND,
      HOLD
   } state_t;

   localparam logic [9:0] WAIT_LOAD  = 10'(KG_LAT - 1);
   localparam logic [6:0] LAST_BIT   = 7'd127;
   localparam logic [3:0] LAST_ROUND = 4'd10;

   state_t        r_state;
   state_t        w_next;
   logic [127:0]  r_keySr;
   logic [6:0]    r_bitCnt;
   logic [9:0]    r_waitCnt;
   logic [3:0]    r_round;

   logic          w_keyReady;
   logic          w_inReady;
   logic          w_outValid;
   logic          w_keyHs;
   logic          w_blkHs;
   logic          w_outHs;

   // Reset is folded into the ready/valid decodes so nothing is offered or accepted on a reset cycle.
   always_comb begin
      w_keyReady = ((r_state == IDLE_NOKEY) || (r_state == READY)) && !reset;
      w_inReady  = (r_state == READY) && !bus.key_valid && !reset;
      w_outValid = (r_state == HOLD) && !reset;
      w_keyHs    = bus.key_valid && w_keyReady;
      w_blkHs    = bus.in_valid && w_inReady;
      w_outHs    = w_outValid && bus.out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE_NOKEY;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE_NOKEY: begin
            if (w_keyHs) w_next = KRST;
         end
         KRST: begin
            w_next = KLOAD;
         end
         KLOAD: begin
            if (r_bitCnt == LAST_BIT) w_next = KWAIT;
         end
         KWAIT: begin
            if (r_waitCnt == 10'd0) w_next = READY;
         end
         READY: begin
            if (w_keyHs) begin
               w_next = KRST;
            end else if (w_blkHs) begin
               w_next = ROUND;
            end
         end
         ROUND: begin
            if (r_round == LAST_ROUND) w_next = HOLD;
         end
         HOLD: begin
            if (w_outHs) w_next = READY;
         end
         default: begin
            w_next = IDLE_NOKEY;
         end
      endcase
   end

   // Each counter is reloaded in the state preceding the one that consumes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_keySr   <= '0;
         r_bitCnt  <= '0;
         r_waitCnt <= '0;
         r_round   <= '0;
      end else begin
         if (w_keyHs) begin
            r_keySr <= bus.key_in;
         end else if (r_state == KLOAD) begin
            r_keySr <= {r_keySr[126:0], 1'b0};
         end

         if (r_state == KRST) begin
            r_bitCnt <= '0;
         end else if (r_state == KLOAD) begin
            r_bitCnt <= r_bitCnt + 7'd1;
         end

         if (r_state == KLOAD) begin
            r_waitCnt <= WAIT_LOAD;
         end else if (r_state == KWAIT) begin
            r_waitCnt <= r_waitCnt - 10'd1;
         end

         if (w_blkHs) begin
            r_round <= 4'd1;
         end else if ((r_state == ROUND) && (r_round != LAST_ROUND)) begin
            r_round <= r_round + 4'd1;
         end
      end
   end

   always_comb begin
      bus.key_ready = w_keyReady;
      bus.in_ready  = w_inReady;
      bus.out_valid = w_outValid;
      kg_reset_n    = !((r_state == KRST) || reset);
      kg_k_in       = (r_state == KLOAD) && r_keySr[127];
      round_idx     = ((r_state == ROUND) || (r_state == HOLD)) ? r_round : 4'd0;
      dp_ld         = w_blkHs;
      dp_rnd_en     = (r_state == ROUND);
      dp_final      = (r_state == ROUND) && (r_round == LAST_ROUND);
      key_loaded    = (r_state == READY) || (r_state == ROUND) || (r_state == HOLD);
      busy          = (r_state != IDLE_NOKEY) && (r_state != READY);
   end

endmodule

// File: doc/aes_key_round_ctrl.md
AES_KEY_ROUND_CTRL -- requirements
Module: aes_key_round_ctrl

Interface
REQ-001 SHALL have parameter KG_LAT, default 176: cycles waited after the last serial key bit before round keys are valid (range 1..1023).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: key_valid  in  1  new cipher key offered; key_in  in  128  cipher key, bit 127 sent first; key_ready  out  1  key accepted when key_valid&key_ready.
REQ-004 SHALL have ports: in_valid  in  1  plaintext block offered; in_ready  out  1  block accepted when in_valid&in_ready.
REQ-005 SHALL have ports: out_valid  out  1  ciphertext ready in datapath; out_ready  in  1  consumer takes block.
REQ-006 SHALL have ports: kg_reset_n  out  1  active-low reset to key-generator; kg_k_in  out  1  serial key bit to key-generator.
REQ-007 SHALL have ports: round_idx  out  4  round-key select (0..10); dp_ld  out  1  load block XOR Key_0; dp_rnd_en  out  1  execute one round; dp_final  out  1  final round, bypass MixColumns.
REQ-008 SHALL have ports: key_loaded  out  1  round keys valid; busy  out  1  state not in IDLE_NOKEY/READY.

Function
REQ-009 SHALL implement states IDLE_NOKEY, KRST, KLOAD, KWAIT, READY, ROUND, HOLD; all outputs registered or decoded from state/counters only.
REQ-010 SHALL assert key_ready only in IDLE_NOKEY and READY.
REQ-011 SHALL, on key handshake, capture key_in into a 128-bit shift register and go to KRST; key_loaded -> 0 next cycle.
REQ-012 SHALL drive kg_reset_n = 0 for exactly the single KRST cycle and 1 in every other non-reset state, then enter KLOAD.
REQ-013 SHALL, in KLOAD, present key bits 127..0 on kg_k_in, one per cycle, for exactly 128 cycles, then enter KWAIT; kg_k_in = 0 outside KLOAD.
REQ-014 SHALL remain in KWAIT exactly KG_LAT cycles, then enter READY with key_loaded = 1.
REQ-015 SHALL assert in_ready only in READY when key_valid = 0 (new key has priority over a simultaneous block).
REQ-016 SHALL, on block handshake (cycle t), assert dp_ld = 1 and round_idx = 0 in cycle t, then enter ROUND.
REQ-017 SHALL, in ROUND, assert dp_rnd_en = 1 for 10 consecutive cycles t+1..t+10 with round_idx = 1..10; dp_final = 1 only when round_idx = 10.
REQ-018 SHALL enter HOLD after round 10 and assert out_valid from cycle t+11 until out_ready = 1; round_idx holds 10 in HOLD.
REQ-019 SHALL, on out_valid&out_ready, return to READY next cycle (min. block-to-block interval 12 cycles).
REQ-020 SHALL ignore key_valid in KRST/KLOAD/KWAIT/ROUND/HOLD; a pending key is accepted on the first READY cycle.
REQ-021 SHALL ignore in_valid in all states except READY; in_valid in IDLE_NOKEY never produces dp_ld.
REQ-022 SHALL keep dp_ld, dp_rnd_en, dp_final, out_valid at 0 outside the states naming them.
REQ-023 SHALL use a 7-bit bit counter and 10-bit wait counter; both saturate-free, reloaded on state entry.

Reset
REQ-024 SHALL, while reset = 1 at a clock edge, enter IDLE_NOKEY and clear counters and shift register.
REQ-025 SHALL reset outputs: key_ready 1 (after reset released, decoded), in_ready 0, out_valid 0, kg_reset_n 0 during reset cycle then 1, kg_k_in 0, round_idx 0, dp_* 0, key_loaded 0, busy 0.
REQ-026 SHALL abort any key load or encryption on reset; no out_valid after a reset mid-operation.

Verification
REQ-027 Key load: key_in = 0x8000...0001, KG_LAT = 4 -> kg_reset_n low 1 cycle; kg_k_in = 1, 126×0, 1; key_loaded = 1 exactly 134 cycles after handshake.
REQ-028 Encrypt: block accepted at t -> dp_ld at t, round_idx 1..10 at t+1..t+10, dp_final only at t+10, out_valid at t+11.
REQ-029 Backpressure: out_ready = 0 for 5 cycles -> out_valid and round_idx = 10 held, in_ready = 0 throughout.
REQ-030 Collision: key_valid and in_valid both high in READY -> key accepted, in_ready = 0, key_loaded drops to 0.
REQ-031 Key request during ROUND -> key_ready = 0 until HOLD exits; key accepted first READY cycle; encryption completes unaffected.
REQ-032 Reset at KLOAD bit 60 and at round 5 -> IDLE_NOKEY, key_loaded = 0, no out_valid, in_ready = 0 afterwards.
